// File: rtl/ro_slave_responder.sv
// ---------------------------------------------------------------------------
// ro_slave_responder
//
// Slave-side responder for one port of the read-only interconnect. It takes a
// held req/addr from the interconnect and issues one read to a synchronous
// SRAM/ROM with 1-cycle read latency. It then inserts WAIT_STATES idle cycles
// and returns the registered read data together with a one-cycle gnt pulse.
// Only one read is in flight at a time. If the interconnect drops req or
// changes addr (the arbiter switched master) before gnt, the access is
// abandoned and the request is re-evaluated from IDLE.
//
// Ports
//   clk                 system clock; all state changes on the rising edge
//   reset               synchronous, active-high
//   slave_data_req_i    read request, held until gnt
//   slave_data_addr_i   word address, valid while req=1
//   slave_data_rdata_o  read data (registered), valid in the gnt cycle
//   slave_data_gnt_o    one-cycle completion strobe
//   mem_en_o            SRAM read enable, one cycle per in-range access
//   mem_addr_o          SRAM address
//   mem_rdata_i         SRAM data, valid one cycle after mem_en_o
// ---------------------------------------------------------------------------
module ro_slave_responder #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned SLAVE_ADDR_WIDTH = 10,
  parameter int unsigned MEM_DEPTH        = 1024,
  parameter int unsigned WAIT_STATES      = 0,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        slave_data_req_i,
  input  logic [SLAVE_ADDR_WIDTH-1:0] slave_data_addr_i,
  output logic [DATA_WIDTH-1:0]       slave_data_rdata_o,
  output logic                        slave_data_gnt_o,
  output logic                        mem_en_o,
  output logic [SLAVE_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [SLAVE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SLAVE_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        err_q, err_d;

  logic in_range;
  logic keep;

  // Widened compare so MEM_DEPTH == 2**SLAVE_ADDR_WIDTH makes every address
  // in range without overflowing the address width.
  assign in_range = (64'(slave_data_addr_i) < 64'(MEM_DEPTH));

  // The access stays alive only while the same master keeps asking for the
  // same word; any change abandons it without a gnt.
  assign keep = slave_data_req_i && (slave_data_addr_i == addr_q);

  assign slave_data_rdata_o = data_q;

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through this block leaves a value unassigned (no latches).
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    mem_addr_d       = mem_addr_q;
    data_d           = data_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    mem_en_o         = 1'b0;
    mem_addr_o       = mem_addr_q;
    slave_data_gnt_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (slave_data_req_i) begin
          addr_d  = slave_data_addr_i;
          err_d   = !in_range;
          state_d = S_READ;
          // Out-of-range reads never touch the SRAM; they still take the
          // READ path so the response timing is identical.
          if (in_range) begin
            mem_en_o   = 1'b1;
            mem_addr_o = slave_data_addr_i;
            mem_addr_d = slave_data_addr_i;
          end
        end
      end

      S_READ: begin
        if (!keep) begin
          state_d = S_IDLE;
        end else begin
          data_d = err_q ? ERR_DATA : mem_rdata_i;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!keep) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        slave_data_gnt_o = keep;
        state_d          = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A reset cycle must not start an SRAM access or complete one.
    if (reset) begin
      mem_en_o         = 1'b0;
      mem_addr_o       = mem_addr_q;
      slave_data_gnt_o = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ro_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_ro_slave_responder
//
// Two responders share one model memory: u0 has no wait states and a
// 512-word implemented range (exercises the out-of-range path); u1 has three
// wait states over the full 1024-word space. Directed steps push the expected
// read data into a per-instance queue; a monitor on the falling edge pops it
// at every gnt and also checks gnt protocol rules and data against the model.
// ---------------------------------------------------------------------------
module tb_ro_slave_responder;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic          clk;
  logic          reset;
  logic          req       [2];
  logic [AW-1:0] addr      [2];
  logic [DW-1:0] rdata     [2];
  logic          gnt       [2];
  logic          mem_en    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_rdata [2];

  logic [DW-1:0] mem [1024];
  logic [31:0]   sb0 [$];
  logic [31:0]   sb1 [$];
  logic          prev_gnt [2];
  bit            rnd_mode;

  int checks;
  int failures;

  ro_slave_responder #(
    .DATA_WIDTH(DW), .SLAVE_ADDR_WIDTH(AW), .MEM_DEPTH(512),
    .WAIT_STATES(0), .ERR_DATA(ERR)
  ) u0 (
    .clk(clk), .reset(reset),
    .slave_data_req_i(req[0]), .slave_data_addr_i(addr[0]),
    .slave_data_rdata_o(rdata[0]), .slave_data_gnt_o(gnt[0]),
    .mem_en_o(mem_en[0]), .mem_addr_o(mem_addr[0]), .mem_rdata_i(mem_rdata[0])
  );

  ro_slave_responder #(
    .DATA_WIDTH(DW), .SLAVE_ADDR_WIDTH(AW), .MEM_DEPTH(1024),
    .WAIT_STATES(3), .ERR_DATA(ERR)
  ) u1 (
    .clk(clk), .reset(reset),
    .slave_data_req_i(req[1]), .slave_data_addr_i(addr[1]),
    .slave_data_rdata_o(rdata[1]), .slave_data_gnt_o(gnt[1]),
    .mem_en_o(mem_en[1]), .mem_addr_o(mem_addr[1]), .mem_rdata_i(mem_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency synchronous SRAM behind each responder.
  always @(posedge clk) begin
    if (mem_en[0]) mem_rdata[0] <= mem[mem_addr[0]];
    if (mem_en[1]) mem_rdata[1] <= mem[mem_addr[1]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned depth(input int i);
    return (i == 0) ? 512 : 1024;
  endfunction

  function automatic logic [31:0] exp_data(input int i, input logic [AW-1:0] a);
    return (32'(a) < depth(i)) ? mem[a] : ERR;
  endfunction

  task automatic push(input int i, input logic [31:0] v);
    if (i == 0) sb0.push_back(v);
    else        sb1.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: protocol rules and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (gnt[i] === 1'b1) begin
        check($sformatf("gnt_has_req%0d", i), {31'd0, req[i]}, 32'd1);
        check($sformatf("gnt_not_adjacent%0d", i), {31'd0, prev_gnt[i]}, 32'd0);
        check($sformatf("rdata_model%0d", i), rdata[i], exp_data(i, addr[i]));
        if (!rnd_mode) begin
          if (i == 0) begin
            check("sb_nonempty0", {31'd0, sb0.size() != 0}, 32'd1);
            if (sb0.size() != 0) check("sb_rdata0", rdata[0], sb0.pop_front());
          end else begin
            check("sb_nonempty1", {31'd0, sb1.size() != 0}, 32'd1);
            if (sb1.size() != 0) check("sb_rdata1", rdata[1], sb1.pop_front());
          end
        end
      end
      prev_gnt[i] = gnt[i];
    end
  end

  // One complete access: request at the current cycle, gnt expected exactly
  // lat cycles later, then the request is dropped.
  task automatic run_read(input int i, input logic [AW-1:0] a, input int lat, input string tag);
    logic en;
    en      = (32'(a) < depth(i));
    req[i]  = 1'b1;
    addr[i] = a;
    #1;
    push(i, exp_data(i, a));
    check({tag, "_mem_en"}, {31'd0, mem_en[i]}, {31'd0, en});
    if (en) check({tag, "_mem_addr"}, 32'(mem_addr[i]), 32'(a));
    for (int c = 1; c <= lat; c++) begin
      step();
      check($sformatf("%s_gnt_c%0d", tag, c), {31'd0, gnt[i]}, {31'd0, c == lat});
      check($sformatf("%s_en_c%0d", tag, c), {31'd0, mem_en[i]}, 32'd0);
    end
    step();
    req[i] = 1'b0;
    #1;
    check({tag, "_gnt_after"}, {31'd0, gnt[i]}, 32'd0);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(508, 515));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic g;
    checks   = 0;
    failures = 0;
    rnd_mode = 1'b0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'hC0DE0000 ^ (k * 32'h9E3779B1);
    mem[5] = 32'h1234_5678;
    prev_gnt[0] = 1'b0;
    prev_gnt[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i]       = 1'b0;
      addr[i]      = '0;
      mem_rdata[i] = '0;
    end
    reset = 1'b1;
    repeat (3) step();

    // Reset state.
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_gnt%0d", i), {31'd0, gnt[i]}, 32'd0);
      check($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
      check($sformatf("rst_mem_en%0d", i), {31'd0, mem_en[i]}, 32'd0);
      check($sformatf("rst_mem_addr%0d", i), 32'(mem_addr[i]), 32'd0);
    end
    reset = 1'b0;
    repeat (7) step();

    // T1: zero wait states, gnt two cycles after the request.
    run_read(0, 10'd5, 2, "t1");
    // T3 and range boundary: 511 is the last implemented word.
    step(); run_read(0, 10'd600, 2, "t3");
    step(); run_read(0, 10'd511, 2, "edge511");
    step(); run_read(0, 10'd512, 2, "edge512");
    // mem_addr_o holds its last driven value while idle.
    step();
    check("mem_addr_hold", 32'(mem_addr[0]), 32'd511);

    // T2: three wait states.
    step(); run_read(1, 10'd7, 5, "t2");
    step(); run_read(1, 10'd1023, 5, "top1023");

    // T4: address switches during WAIT; the new read restarts from IDLE.
    step();
    req[1] = 1'b1; addr[1] = 10'd5; #1;
    check("t4_first_en", {31'd0, mem_en[1]}, 32'd1);
    step();
    check("t4_read_gnt", {31'd0, gnt[1]}, 32'd0);
    step();
    addr[1] = 10'd9; #1;
    check("t4_wait_gnt", {31'd0, gnt[1]}, 32'd0);
    check("t4_wait_en", {31'd0, mem_en[1]}, 32'd0);
    step();
    run_read(1, 10'd9, 5, "t4");

    // T5: held request gives a gnt every third cycle.
    step();
    req[0] = 1'b1; addr[0] = 10'd3; #1;
    for (int c = 0; c < 21; c++) begin
      if (c % 3 == 0) begin
        push(0, mem[3]);
        check($sformatf("t5_en_c%0d", c), {31'd0, mem_en[0]}, 32'd1);
      end
      check($sformatf("t5_gnt_c%0d", c), {31'd0, gnt[0]}, {31'd0, c % 3 == 2});
      step();
    end
    req[0] = 1'b0; #1;
    check("t5_gnt_end", {31'd0, gnt[0]}, 32'd0);

    // T6: reset during WAIT abandons the access.
    step();
    req[1] = 1'b1; addr[1] = 10'd7; #1;
    step(); step();
    reset = 1'b1; #1;
    check("t6_gnt_in_reset", {31'd0, gnt[1]}, 32'd0);
    step();
    check("t6_gnt", {31'd0, gnt[1]}, 32'd0);
    check("t6_rdata", rdata[1], 32'd0);
    check("t6_mem_en", {31'd0, mem_en[1]}, 32'd0);
    check("t6_mem_addr", 32'(mem_addr[1]), 32'd0);
    req[1] = 1'b0;
    reset  = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("t6_no_late_gnt%0d", c), {31'd0, gnt[1]}, 32'd0);
    end

    // Random req/addr traffic on u0; the monitor checks every gnt.
    rnd_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      g = gnt[0];
      step();
      if (!req[0]) begin
        if ($urandom_range(0, 2) != 0) begin
          req[0]  = 1'b1;
          addr[0] = pick_addr();
        end
      end else if (g || $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) req[0] = 1'b0;
        else                           addr[0] = pick_addr();
      end
      #1;
    end
    req[0] = 1'b0;
    repeat (6) step();

    check("sb0_drained", sb0.size(), 32'd0);
    check("sb1_drained", sb1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
